// File: rtl/stopwatch_lap_counter.sv
// Stopwatch timing core: BCD m:ss.t counter with start/stop/resume, lap-hold and clear.
// Optional lap-hold (LAP state + snapshot register) is built only when STOPWATCH_LAP_EN is defined.

// One BCD digit of the chain; wraps at MAX and reports carry on the wrapping increment.
module stopwatch_lap_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);
  assign carry = inc && (q == 4'(MAX));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)  q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= carry ? 4'd0 : q + 4'd1;
  end
endmodule

module stopwatch_lap_counter #(
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       lapClear,
  output logic [3:0] swMin,
  output logic [3:0] swSec1,
  output logic [3:0] swSec0,
  output logic [3:0] swTenth,
  output logic       running,
  output logic       lapHeld,
  output logic       overflow
);
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
`ifdef STOPWATCH_LAP_EN
    , LAP = 2'd3
`endif
  } state_t;

  state_t          state, state_nxt;
  logic            prev_start, prev_stop, prev_lap;
  logic            start_p, stop_p, lap_p;
  logic            clr, count_en, tick, lap_mode;
  logic [PW-1:0]   presc;
  logic [4:0]      inc;
  logic [3:0][3:0] live, disp;

  // Button edge detection: only the rising edge of each level acts.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_start <= 1'b0;
      prev_stop  <= 1'b0;
      prev_lap   <= 1'b0;
    end else begin
      prev_start <= start_resume;
      prev_stop  <= stop;
      prev_lap   <= lapClear;
    end
  end

  assign start_p = start_resume & ~prev_start;
  assign stop_p  = stop & ~prev_stop;
  assign lap_p   = lapClear & ~prev_lap;

`ifdef STOPWATCH_LAP_EN
  logic            snap_ld;
  logic [3:0][3:0] snap;

  assign lap_mode = (state == LAP);
`else
  assign lap_mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Ignored buttons never block a lower-priority press that does act.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
`ifdef STOPWATCH_LAP_EN
    snap_ld   = 1'b0;
`endif
    case (state)
      IDLE:  if (start_p) state_nxt = RUN;
      RUN: begin
        if (stop_p) state_nxt = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_p) begin
          state_nxt = LAP;
          snap_ld   = 1'b1;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (stop_p)     state_nxt = PAUSE;
        else if (lap_p) state_nxt = RUN;
      end
`endif
      PAUSE: begin
        if (lap_p) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (start_p) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counting follows the state before the edge, so a stop still lets the tick land.
  assign count_en = (state == RUN) || lap_mode;
  assign tick     = count_en && (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)       presc <= '0;
    else if (clr)      presc <= '0;
    else if (count_en) presc <= tick ? '0 : presc + PW'(1);
  end

  assign inc[0] = tick;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_dig
      localparam int DMAX = (i == 2) ? 5 : 9;
      stopwatch_lap_digit #(.MAX(DMAX)) u_dig (
        .clk    (clk),
        .resetN (resetN),
        .clr    (clr),
        .inc    (inc[i]),
        .q      (live[i]),
        .carry  (inc[i+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)     overflow <= 1'b0;
    else if (clr)    overflow <= 1'b0;
    else if (inc[4]) overflow <= 1'b1;
  end

`ifdef STOPWATCH_LAP_EN
  // Snapshot takes the pre-increment live value.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      snap <= '0;
    else if (snap_ld) snap <= live;
  end

  assign disp = lap_mode ? snap : live;
`else
  assign disp = live;
`endif

  assign swTenth = disp[0];
  assign swSec0  = disp[1];
  assign swSec1  = disp[2];
  assign swMin   = disp[3];
  assign running = (state == RUN) || lap_mode;
  assign lapHeld = lap_mode;
endmodule

// File: doc/stopwatch_lap_counter.md
# stopwatch_lap_counter

- Timing core for the watch controller's STOPWATCH mode.
- Counts elapsed time in BCD (minutes, tens of seconds, seconds, tenths) from a single system clock.
- Supports start/stop/resume, lap-hold and clear.
- Feeds the four stopwatch display digits (min, sec1, sec0, tenth) consumed by the watch controller's mode multiplexer.

## Interface
Parameters:
- TICK_DIV, default 5000000: clk cycles per 0.1 s tick. Must be ≥ 2. Prescaler width is $clog2(TICK_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- start_resume  input  1  start/resume button. Level input, synchronous and debounced upstream.
- stop  input  1  stop button. Level input, synchronous and debounced upstream.
- lapClear  input  1  lap (while running) / clear (while paused). Level input, synchronous and debounced upstream.
- swMin  output  4  minutes digit, 0–9.
- swSec1  output  4  tens-of-seconds digit, 0–5.
- swSec0  output  4  seconds digit, 0–9.
- swTenth  output  4  tenths digit, 0–9.
- running  output  1  high in RUN or LAP.
- lapHeld  output  1  high in LAP.
- overflow  output  1  sticky wrap flag.

## Operation
- **Edge detection:** each button has a `prev` register. press = input & ~prev. Only presses act; held levels are ignored.
- **Simultaneous presses:** priority is stop > lapClear > start_resume. One action per edge.
- **State transitions (FSM states IDLE, RUN, PAUSE, LAP):**
  - IDLE: start → RUN. stop and lapClear are ignored.
  - RUN: stop → PAUSE. lapClear → LAP, and the snapshot register captures the live digits. start is ignored.
  - LAP: lapClear → RUN, and the display returns to live. stop → PAUSE, and the display shows live. start is ignored.
  - PAUSE: start → RUN. lapClear → IDLE, which zeroes the digits, prescaler and overflow. stop is ignored.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 only in RUN/LAP.
  - Holds its value in PAUSE, so resume keeps the sub-tick phase.
  - Cleared only by reset or entry to IDLE.
- **Tick:** occurs when the prescaler equals TICK_DIV-1. The prescaler goes to 0 and the BCD chain increments:
  - tenth 9→0 carries into sec0.
  - sec0 9→0 carries into sec1.
  - sec1 5→0 carries into min.
  - min 9→0 means the count wraps.
- **Wrap:** 9:59.9 + tick → 0:00.0 and sets overflow. Counting continues.
- **Outputs:** digit outputs come from the snapshot register in LAP and from the live counter otherwise. The selection mux uses registered sources only.
- **Digit encoding:** digits are always legal BCD. No value above 9 (above 5 for sec1) is ever produced.

## Timing
- **Reset:** resetN low immediately forces, without a clock:
  - state IDLE;
  - all digits, snapshot and prescaler to 0;
  - all prev registers to 0;
  - running, lapHeld and overflow to 0.
- **Reset mid-run:** same forcing; nothing is retained.
- **Button latency:**
  - A press first sampled high at edge N changes state at edge N.
  - running/lapHeld/digit-source changes are visible after edge N.
- **Start-to-tick:** a start at edge N, from IDLE, gives the first tick increment at edge N+TICK_DIV.
- **Counting qualifier:** counting at an edge is governed by the state before that edge.
  - A tick coinciding with a stop press still increments.
  - A tick coinciding with a start press from PAUSE/IDLE does not increment.
- **Snapshot:** the snapshot taken at edge N equals the live digits before edge N's increment.
- **Overflow:** asserts after the wrapping edge. It stays high until reset or IDLE entry.

## Configuration
- STOPWATCH_LAP_EN defined:
  - LAP state and snapshot register exist, as above.
- STOPWATCH_LAP_EN undefined:
  - No LAP state and no snapshot register.
  - lapClear in RUN is ignored; it only clears from PAUSE.
  - lapHeld is tied to 0.
  - Digits always show the live count.

## Test plan
- Reset: drive resetN low mid-count with no clock edge → all digits, running, lapHeld and overflow are 0 immediately. Release, then 10 idle cycles → still 0:00.0.
- Basic count, TICK_DIV=4:
  - Start pressed at edge N → running=1.
  - Value is 0:00.1 after edge N+4.
  - Value is 0:01.0 after edge N+40.
- Pause/resume, TICK_DIV=4:
  - Stop at prescaler=2 → digits frozen for 100 cycles.
  - Start → next tick arrives 2 edges later, not 4.
  - Start, stop and lapClear asserted on the same edge → PAUSE.
- Lap (STOPWATCH_LAP_EN):
  - Lap at 0:00.5 → outputs hold 0:00.5 with lapHeld=1 while ticks continue.
  - Lap again after 8 more ticks → outputs show 0:01.3 and lapHeld=0.
- Wrap, TICK_DIV=2:
  - Run 6000 ticks → 0:00.0 and overflow=1; counting continues to 0:00.1.
  - Stop then lapClear → IDLE, all zero, overflow=0.
- Build without STOPWATCH_LAP_EN: lapClear during RUN → no change, lapHeld stays 0, count continues.
